// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared constants and types for the buffered 1-to-2 demultiplexer.
//   DEMUX_WIDTH_DEF : default data width
//   DEMUX_DEPTH_DEF : default per-channel FIFO depth (power of two, >= 2)
//   DEMUX_CNT_W     : width of the optional delivered-word counters
//   demux_ch_t      : output channel identifier (CH0 / CH1)
// -----------------------------------------------------------------------------
package demux_pkg;

  localparam int DEMUX_WIDTH_DEF = 8;
  localparam int DEMUX_DEPTH_DEF = 2;
  localparam int DEMUX_CNT_W     = 16;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } demux_ch_t;

  // Map the raw select input onto a channel identifier.
  function automatic demux_ch_t ch_from_sel(input logic sel);
    return sel ? CH1 : CH0;
  endfunction

endpackage : demux_pkg

// File: rtl/demux_chan_fifo.sv
// -----------------------------------------------------------------------------
// demux_chan_fifo
// Small per-channel FIFO used by the demultiplexer. The state is an occupancy
// counter (0..DEPTH) plus read/write pointers that wrap modulo DEPTH. Storage
// is cleared on reset so that the head data reads as zero afterwards.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   push       in   write push_data (ignored when full)
//   push_data  in   WIDTH-bit word to store
//   pop        in   drop the head entry (ignored when empty)
//   head_data  out  oldest stored word
//   empty      out  occupancy == 0
//   full       out  occupancy == DEPTH
// -----------------------------------------------------------------------------
module demux_chan_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEF,
  parameter int DEPTH = DEMUX_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic do_push;
  logic do_pop;

  assign empty = (occ_q == '0);
  assign full  = (occ_q == OCC_FULL);

  // Guard both operations locally so a misbehaving parent can never overrun
  // or underrun the buffer.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;   // power-of-two depth: natural wrap
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    unique case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule : demux_chan_fifo

// File: rtl/demux_1x2_8bits_buf.sv
// -----------------------------------------------------------------------------
// demux_1x2_8bits_buf
// Buffered 1-to-2 demultiplexer. Words arriving on a valid/ready input are
// steered by MS into one of two per-channel FIFOs; each FIFO drives its own
// valid/ready output. A stalled sink only blocks words addressed to it.
//
// Ports:
//   clk                       in   clock, rising edge
//   rst                       in   synchronous active-high reset
//   MS                        in   channel select for D_in (0 -> ch0, 1 -> ch1)
//   D_in                      in   input word
//   in_valid                  in   input word present
//   in_ready                  out  selected channel has room (low during rst)
//   D_out_0 / D_out_1         out  channel head data
//   out_valid_0 / out_valid_1 out  channel head valid
//   out_ready_0 / out_ready_1 in   sink accepts head word
//   cnt_0 / cnt_1             out  saturating delivered-word counters
//                                  (only when DEMUX_STATS_EN is defined)
//
// Build option: define DEMUX_STATS_EN to add the delivered-word counters.
// -----------------------------------------------------------------------------
module demux_1x2_8bits_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEF,
  parameter int DEPTH = DEMUX_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MS,
  input  logic [WIDTH-1:0]       D_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       D_out_0,
  output logic [WIDTH-1:0]       D_out_1,
  output logic                   out_valid_0,
  output logic                   out_valid_1,
`ifdef DEMUX_STATS_EN
  output logic [DEMUX_CNT_W-1:0] cnt_0,
  output logic [DEMUX_CNT_W-1:0] cnt_1,
`endif
  input  logic                   out_ready_0,
  input  logic                   out_ready_1
);

  localparam int NUM_CH = 2;

  demux_ch_t        sel_ch;
  logic             in_fire;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       empty;
  logic [1:0]       full;
  logic [1:0]       sink_ready;
  logic [WIDTH-1:0] head [NUM_CH];

  // --- select decode and input handshake ------------------------------------
  assign sel_ch = ch_from_sel(MS);

  // Only registered full flags feed in_ready, so there is no combinational
  // path from the sinks' ready back to the source.
  assign in_ready = ~full[sel_ch] & ~rst;
  assign in_fire  = in_valid & in_ready;

  assign push[0] = in_fire & (sel_ch == CH0);
  assign push[1] = in_fire & (sel_ch == CH1);

  assign sink_ready = {out_ready_1, out_ready_0};

  // --- per-channel buffers ---------------------------------------------------
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_chan
    assign pop[gi] = ~empty[gi] & sink_ready[gi];

    demux_chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[gi]),
      .push_data (D_in),
      .pop       (pop[gi]),
      .head_data (head[gi]),
      .empty     (empty[gi]),
      .full      (full[gi])
    );
  end

  assign D_out_0     = head[0];
  assign D_out_1     = head[1];
  assign out_valid_0 = ~empty[0];
  assign out_valid_1 = ~empty[1];

`ifdef DEMUX_STATS_EN
  // --- optional delivered-word counters (saturating) ------------------------
  logic [DEMUX_CNT_W-1:0] cnt_q [NUM_CH];
  logic [DEMUX_CNT_W-1:0] cnt_d [NUM_CH];

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c] = cnt_q[c];
      if (pop[c] && (cnt_q[c] != '1)) begin
        cnt_d[c] = cnt_q[c] + DEMUX_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign cnt_0 = cnt_q[0];
  assign cnt_1 = cnt_q[1];
`endif

endmodule : demux_1x2_8bits_buf

// File: doc/demux_1x2_8bits_buf.md
# demux_1x2_8bits_buf

Buffered 1-to-2 demultiplexer that steers 8-bit words from one valid/ready source to one of two valid/ready sinks, selected per word by `MS`. It is the companion to the 2:1 data mux in the Natural-Logarithm datapath: the mux merges two operand streams, and this block splits one result stream back to two consumers. Each output channel has its own small FIFO, so a stalled sink blocks only words addressed to it.

## Interface
- `WIDTH`, default 8, data width in bits.
- `DEPTH`, default 2, entries per channel FIFO; must be a power of two and at least 2.

- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `MS`  in  1  channel select for the word on `D_in`; 0 selects channel 0, 1 selects channel 1.
- `D_in`  in  WIDTH  input data.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block can accept the word for the currently selected channel.
- `D_out_0`, `D_out_1`  out  WIDTH  channel head data.
- `out_valid_0`, `out_valid_1`  out  1  channel head valid.
- `out_ready_0`, `out_ready_1`  in  1  sink accepts the head word.
- `cnt_0`, `cnt_1`  out  16  delivered-word counters. Present only with `DEMUX_STATS_EN`.

## Operation
- Input handshake: `in_fire = in_valid & in_ready`. On `in_fire`, `D_in` is pushed into FIFO[`MS`]. `MS` is sampled only on `in_fire`.
- `in_ready`:
  - equals `~full[MS] & ~rst`;
  - is derived from registered full flags only, with no combinational path from `out_ready_*`.
- Output handshake, per channel c: `out_fire_c = out_valid_c & out_ready_c` pops the head. `out_valid_c = ~empty[c]`. `D_out_c` is the head entry.
- Per-channel FIFO state is an occupancy counter, 0..DEPTH:
  - EMPTY (0): push → PARTIAL, or FULL if DEPTH = 1 (not allowed).
  - PARTIAL: push alone increments; pop alone decrements; push and pop together leave the count unchanged and advance both pointers.
  - FULL (DEPTH): only pop is possible, because `in_ready` is low for this channel. There is no bypass or overwrite.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Words are delivered in order within a channel. There is no ordering guarantee between channels.
- `in_valid` low: nothing is pushed, whatever `MS`, `D_in` or `in_ready` are.
- Changing `MS` while `in_valid` is high and `in_ready` is low is legal. `in_ready` re-evaluates for the new channel.

## Timing
- Reset (synchronous, takes effect at the clock edge with `rst` = 1):
  - occupancies, pointers and storage cleared;
  - `out_valid_*` = 0 and `D_out_*` = 0;
  - `cnt_*` = 0;
  - `in_ready` = 0 while `rst` is high, and 1 in the first cycle after release.
- Reset mid-operation discards all buffered words. No `out_valid` is asserted in the cycle after reset.
- Latency: a word accepted at edge N is visible on `out_valid_c`/`D_out_c` after edge N, i.e. from cycle N+1. There is no same-cycle pass-through.
- Throughput is 1 word/cycle per channel when the sink holds ready high.
- `D_out_c` is stable while `out_valid_c = 1` and `out_ready_c = 0`.

## Configuration
- `DEMUX_STATS_EN` defined:
  - `cnt_0` and `cnt_1` are ports;
  - each increments by 1 on its channel's `out_fire`;
  - each saturates at 16'hFFFF and holds;
  - each clears on `rst`.
- `DEMUX_STATS_EN` undefined: counter ports and logic are absent. Datapath behaviour is identical.

## Structure
- Package `demux_pkg` holds:
  - `DEMUX_WIDTH_DEF` = 8, `DEMUX_DEPTH_DEF` = 2, `DEMUX_CNT_W` = 16;
  - channel typedef `demux_ch_t` with CH0 = 0 and CH1 = 1.
- Sub-module `demux_chan_fifo` (WIDTH, DEPTH): push/pop, head data, empty/full, synchronous reset. It is instantiated twice.
- The top level contains select decode, `in_ready` generation and the optional counters.

## Test plan
- Reset release, then MS = 0, D_in = 8'hA5, one valid cycle → `out_valid_0` = 1 next cycle with `D_out_0` = 8'hA5; `out_valid_1` stays 0.
- `out_ready_1` = 0; push 8'h11, 8'h22 to channel 1, then attempt 8'h33 → `in_ready` = 0 with MS = 1. Switch MS to 0 → `in_ready` = 1, and 8'h33 is delivered on channel 0 while channel 1 still holds 8'h11.
- Channel 0 FIFO held at one entry; push and pop in the same cycle for 10 cycles with data 0..9 → output sequence 0..9 in order, occupancy constant, one word per cycle.
- Alternate MS every word, data 1..8, both ready high → channel 0 receives 1, 3, 5, 7 and channel 1 receives 2, 4, 6, 8.
- Fill both channels, then assert `rst` for one cycle → all `out_valid` = 0 afterwards, `in_ready` = 0 during reset and 1 after it, and the buffered words never appear.
- With `DEMUX_STATS_EN`, preload `cnt_0` near saturation by forcing 65,537 deliveries → `cnt_0` = 16'hFFFF and holds; `cnt_1` unchanged.
